gpio_ctrl_hub: RTL and testbench



---
 rtl/gpio_ctrl_hub_pkg.sv | 29 ++
 rtl/gpio_ctrl_hub_if.sv | 14 +
 rtl/gpio_reset_channel.sv | 109 ++++++++++
 rtl/gpio_ctrl_hub.sv | 118 +++++++++++
 tb/tb_gpio_ctrl_hub.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/gpio_ctrl_hub_pkg.sv
// gpio_ctrl_hub_pkg
//   Shared definitions for the GPIO control hub: GPIO_O / GPIO_I bit
//   positions, the per-channel reset FSM encoding and a counter-width helper.
package gpio_ctrl_hub_pkg;

    // GPIO_O (PS -> hub) bit positions
    localparam int REQ_BASE  = 16;  // [16+i] reset request, rising edge triggers
    localparam int CLR_BIT   = 20;  // sticky clear, rising edge triggers
    localparam int CACHE_BIT = 24;  // cache_en level
    localparam int BSEL_BIT  = 25;  // bram_sel level

    // GPIO_I (hub -> PS) bit positions
    localparam int ACT_BASE  = 16;  // [16+i] channel active
    localparam int BUSY_BASE = 20;  // [20+i] synchronised rst_busy
    localparam int TO_BASE   = 24;  // [24+i] timeout sticky
    localparam int ANY_BIT   = 28;  // OR of active bits

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_WAIT   = 2'd2
    } chan_state_e;

    // Bits needed to hold 0..n inclusive.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/gpio_ctrl_hub_if.sv
// gpio_ctrl_hub_if
//   The PS AXI GPIO triple as seen by the hub.
//   GPIO_O : PS output word (control bits)
//   GPIO_T : PS tristate word (carried for completeness, not used)
//   GPIO_I : status word returned to the PS
//   master : PS side, slave : hub side.
interface gpio_ctrl_hub_if;
    logic [31:0] GPIO_O;
    logic [31:0] GPIO_T;
    logic [31:0] GPIO_I;

    modport master (output GPIO_O, output GPIO_T, input GPIO_I);
    modport slave  (input GPIO_O, input GPIO_T, output GPIO_I);
endinterface

// File: rtl/gpio_reset_channel.sv
// gpio_reset_channel
//   One reset channel: busy synchroniser, IDLE -> ASSERT -> WAIT -> IDLE FSM
//   with a pulse counter and a busy-timeout counter, plus the timeout sticky.
//   clk, rst_n  : clock, async active-low reset
//   req_edge    : one-cycle request trigger (already synchronised)
//   clr_edge    : one-cycle sticky clear trigger
//   busy_in     : asynchronous reset-busy from the reset target
//   pulse       : registered reset output of this channel (ASSERT)
//   active      : registered, high whenever the FSM is not IDLE
//   busy_sync   : synchronised busy_in
//   to_sticky   : timeout sticky; a set in the same cycle as a clear wins
module gpio_reset_channel
    import gpio_ctrl_hub_pkg::*;
#(
    parameter int RST_PULSE    = 16,
    parameter int BUSY_TIMEOUT = 1024,
    parameter int SYNC_STAGES  = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_edge,
    input  logic clr_edge,
    input  logic busy_in,
    output logic pulse,
    output logic active,
    output logic busy_sync,
    output logic to_sticky
);
    localparam int PW = cnt_w(RST_PULSE);
    localparam int TW = cnt_w(BUSY_TIMEOUT);
    localparam logic [PW-1:0] PULSE_LD = PW'(RST_PULSE);
    localparam logic [TW-1:0] TO_LAST  = TW'(BUSY_TIMEOUT - 1);
    localparam logic [TW-1:0] TO_SAT   = TW'(BUSY_TIMEOUT);

    logic [SYNC_STAGES-1:0] busy_ff;
    chan_state_e            state;
    logic [PW-1:0]          pcnt;
    logic [TW-1:0]          tcnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_ff <= '0;
        end else begin
            busy_ff[0] <= busy_in;
            for (int s = 1; s < SYNC_STAGES; s++) busy_ff[s] <= busy_ff[s-1];
        end
    end
    assign busy_sync = busy_ff[SYNC_STAGES-1];

    // pulse/active are set alongside the state so they are flops that
    // always agree with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            pcnt      <= '0;
            tcnt      <= '0;
            pulse     <= 1'b0;
            active    <= 1'b0;
            to_sticky <= 1'b0;
        end else begin
            if (clr_edge) to_sticky <= 1'b0;    // a timeout set below overrides
            case (state)
                ST_IDLE: begin
                    if (req_edge) begin
                        state  <= ST_ASSERT;
                        pcnt   <= PULSE_LD;
                        pulse  <= 1'b1;
                        active <= 1'b1;
                    end
                end
                ST_ASSERT: begin
                    if (req_edge) begin
                        pcnt <= PULSE_LD;       // retrigger restarts the pulse
                    end else if (pcnt <= PW'(1)) begin
                        state <= ST_WAIT;
                        tcnt  <= '0;
                        pulse <= 1'b0;
                    end else begin
                        pcnt <= pcnt - PW'(1);
                    end
                end
                ST_WAIT: begin
                    if (req_edge) begin
                        state <= ST_ASSERT;
                        pcnt  <= PULSE_LD;
                        pulse <= 1'b1;
                    end else if (!busy_sync) begin
                        state  <= ST_IDLE;
                        active <= 1'b0;
                    end else if (tcnt >= TO_LAST) begin
                        // this cycle is the BUSY_TIMEOUT-th spent waiting
                        state     <= ST_IDLE;
                        active    <= 1'b0;
                        to_sticky <= 1'b1;
                        tcnt      <= TO_SAT;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    pulse  <= 1'b0;
                    active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/gpio_ctrl_hub.sv
// gpio_ctrl_hub
//   Glue between the PS AXI GPIO and the model's reset/mode inputs.
//   ap_clk, ap_rst_n : clock, async active-low reset
//   gpio             : GPIO_O (control in), GPIO_T (ignored), GPIO_I (status out)
//   debug            : debug word, registered into GPIO_I[DEBUG_W-1:0]
//   rst_busy         : per-channel reset-busy inputs (asynchronous)
//   rst_out          : per-channel reset pulses (0 system, 1 param, 2 grad)
//   cache_en         : synchronised GPIO_O[24], one extra register
//   bram_sel         : synchronised GPIO_O[25], only taken while all channels idle
// GPIO_I active/any bits come straight from the channel FSM flops so they drop
// on the same edge the FSM reaches IDLE; debug, busy and timeout fields go
// through one more status register.
module gpio_ctrl_hub
    import gpio_ctrl_hub_pkg::*;
#(
    parameter int N_RST        = 3,
    parameter int RST_PULSE    = 16,
    parameter int BUSY_TIMEOUT = 1024,
    parameter int SYNC_STAGES  = 2,
    parameter int DEBUG_W      = 16,
    parameter int CASCADE      = 1
) (
    input  logic               ap_clk,
    input  logic               ap_rst_n,
    gpio_ctrl_hub_if.slave     gpio,
    input  logic [DEBUG_W-1:0] debug,
    input  logic [N_RST-1:0]   rst_busy,
    output logic [N_RST-1:0]   rst_out,
    output logic               cache_en,
    output logic               bram_sel
);
    // Only the used GPIO_O bits are synchronised: {bsel, cache, clr, req[N_RST-1:0]}
    localparam int SW = N_RST + 3;
    localparam int I_CLR   = N_RST;
    localparam int I_CACHE = N_RST + 1;
    localparam int I_BSEL  = N_RST + 2;

    logic [SW-1:0]                  o_raw;
    logic [SYNC_STAGES-1:0][SW-1:0] o_ff;
    logic [SW-1:0]                  o_sync;
    logic [N_RST:0]                 hist;
    logic [N_RST:0]                 trig;

    logic [N_RST-1:0]   pulse, active, busy_sync, to_sticky;
    logic [DEBUG_W-1:0] debug_q;
    logic [N_RST-1:0]   busy_q, sticky_q;
    logic               unused_ok;

    assign o_raw = {gpio.GPIO_O[BSEL_BIT], gpio.GPIO_O[CACHE_BIT],
                    gpio.GPIO_O[CLR_BIT], gpio.GPIO_O[REQ_BASE +: N_RST]};
    assign unused_ok = ^{gpio.GPIO_T, gpio.GPIO_O};

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            o_ff <= '0;
            hist <= '0;
        end else begin
            o_ff[0] <= o_raw;
            for (int s = 1; s < SYNC_STAGES; s++) o_ff[s] <= o_ff[s-1];
            hist <= o_sync[N_RST:0];
        end
    end
    assign o_sync = o_ff[SYNC_STAGES-1];

    // History resets to 0, so a bit already high at reset release triggers once.
    assign trig = o_sync[N_RST:0] & ~hist;

    for (genvar i = 0; i < N_RST; i++) begin : g_ch
        gpio_reset_channel #(
            .RST_PULSE   (RST_PULSE),
            .BUSY_TIMEOUT(BUSY_TIMEOUT),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ch (
            .clk      (ap_clk),
            .rst_n    (ap_rst_n),
            .req_edge (trig[i]),
            .clr_edge (trig[I_CLR]),
            .busy_in  (rst_busy[i]),
            .pulse    (pulse[i]),
            .active   (active[i]),
            .busy_sync(busy_sync[i]),
            .to_sticky(to_sticky[i])
        );
    end

    // Cascade is an OR of flop outputs only; channel FSMs are not disturbed.
    always_comb begin
        rst_out = pulse;
        if (CASCADE != 0) rst_out = pulse | {N_RST{pulse[0]}};
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            debug_q  <= '0;
            busy_q   <= '0;
            sticky_q <= '0;
            cache_en <= 1'b0;
            bram_sel <= 1'b0;
        end else begin
            debug_q  <= debug;
            busy_q   <= busy_sync;
            sticky_q <= to_sticky;
            cache_en <= o_sync[I_CACHE];
            // bank switch only while no reset sequence is in flight
            if (!(|active)) bram_sel <= o_sync[I_BSEL];
        end
    end

    always_comb begin
        gpio.GPIO_I = '0;
        gpio.GPIO_I[DEBUG_W-1:0]          = debug_q;
        gpio.GPIO_I[ACT_BASE  +: N_RST]   = active;
        gpio.GPIO_I[BUSY_BASE +: N_RST]   = busy_q;
        gpio.GPIO_I[TO_BASE   +: N_RST]   = sticky_q;
        gpio.GPIO_I[ANY_BIT]              = |active;
    end

endmodule

// File: tb/tb_gpio_ctrl_hub.sv
// tb_gpio_ctrl_hub
//   Directed stimulus pushes (cycle, signal, mask, value) expectations into a
//   scoreboard; a negedge monitor compares each entry when its cycle arrives.
module tb_gpio_ctrl_hub;
    localparam int S_GPI  = 0;
    localparam int S_RST  = 1;
    localparam int S_CACH = 2;
    localparam int S_BSEL = 3;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic [15:0] debug;
    logic [2:0]  rst_busy;
    logic [2:0]  rst_out;
    logic        cache_en, bram_sel;

    gpio_ctrl_hub_if gpio_bus ();

    gpio_ctrl_hub #(
        .N_RST(3), .RST_PULSE(16), .BUSY_TIMEOUT(64),
        .SYNC_STAGES(2), .DEBUG_W(16), .CASCADE(1)
    ) dut (
        .ap_clk  (ap_clk),
        .ap_rst_n(ap_rst_n),
        .gpio    (gpio_bus),
        .debug   (debug),
        .rst_busy(rst_busy),
        .rst_out (rst_out),
        .cache_en(cache_en),
        .bram_sel(bram_sel)
    );

    always #5 ap_clk = ~ap_clk;

    int cyc = 0;
    always @(posedge ap_clk) cyc <= cyc + 1;

    typedef struct {
        int          at;
        int          sig;
        logic [31:0] mask;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic void expect_at(input int at, input int sig, input logic [31:0] mask,
                                      input logic [31:0] val, input string name);
        exp_t e;
        e.at = at; e.sig = sig; e.mask = mask; e.val = val; e.name = name;
        sb.push_back(e);
    endfunction

    always @(negedge ap_clk) begin
        logic [31:0] act;
        for (int j = sb.size() - 1; j >= 0; j--) begin
            if (sb[j].at <= cyc) begin
                case (sb[j].sig)
                    S_GPI:   act = gpio_bus.GPIO_I;
                    S_RST:   act = {29'd0, rst_out};
                    S_CACH:  act = {31'd0, cache_en};
                    default: act = {31'd0, bram_sel};
                endcase
                n_vec++;
                if (sb[j].at != cyc) begin
                    n_err++;
                    $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)",
                             sb[j].name, sb[j].at, cyc);
                end else if ((act & sb[j].mask) !== sb[j].val) begin
                    n_err++;
                    $display("FAIL %s @cycle %0d: got %h, want %h", sb[j].name, cyc,
                             act & sb[j].mask, sb[j].val);
                end
                sb.delete(j);
            end
        end
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge ap_clk);
    endtask

    initial begin
        int c, d, e, r;
        ap_rst_n = 1'b0;
        gpio_bus.GPIO_O = '0;
        gpio_bus.GPIO_T = 32'hFFFF_FFFF;
        debug    = 16'hA5A5;
        rst_busy = '0;

        // reset state
        wait_n(2); c = cyc;
        expect_at(c + 1, S_GPI,  32'hFFFF_FFFF, 32'h0, "reset_gpio_i");
        expect_at(c + 1, S_RST,  32'h7, 32'h0, "reset_rst_out");
        expect_at(c + 1, S_CACH, 32'h1, 32'h0, "reset_cache_en");
        expect_at(c + 1, S_BSEL, 32'h1, 32'h0, "reset_bram_sel");
        wait_n(1); ap_rst_n = 1'b1; c = cyc;
        expect_at(c + 1, S_GPI, 32'h0000_FFFF, 32'h0000_A5A5, "debug_a5a5");
        wait_n(3); debug = 16'h1234; c = cyc;
        expect_at(c + 1, S_GPI, 32'h0000_FFFF, 32'h0000_1234, "debug_1234");
        expect_at(c + 2, S_RST, 32'h7, 32'h0, "idle_no_pulse");

        // single pulse on channel 1, request held high
        wait_n(2); c = cyc; gpio_bus.GPIO_O[17] = 1'b1;
        expect_at(c + 2, S_RST, 32'h7, 32'h0, "p1_pre");
        for (int j = 0; j < 16; j++) expect_at(c + 3 + j, S_RST, 32'h7, 32'h2, "p1_high");
        for (int j = 19; j < 46; j++) expect_at(c + j, S_RST, 32'h7, 32'h0, "p1_low");
        expect_at(c + 10, S_GPI, 32'h1000_0000, 32'h1000_0000, "p1_any");
        expect_at(c + 19, S_GPI, 32'h0002_0000, 32'h0002_0000, "p1_active_wait");
        expect_at(c + 20, S_GPI, 32'h1002_0000, 32'h0, "p1_idle");
        wait_n(46); gpio_bus.GPIO_O[17] = 1'b0;

        // busy wait on channel 2, with bram_sel guard and cache_en latency
        wait_n(3); c = cyc; gpio_bus.GPIO_O[18] = 1'b1;
        expect_at(c + 3,  S_RST, 32'h7, 32'h4, "bw_pulse");
        expect_at(c + 19, S_RST, 32'h7, 32'h0, "bw_pulse_end");
        expect_at(c + 30, S_GPI, 32'h0040_0000, 32'h0040_0000, "bw_busy_vis");
        expect_at(c + 61, S_GPI, 32'h0004_0000, 32'h0004_0000, "bw_active_held");
        expect_at(c + 62, S_GPI, 32'h0004_0000, 32'h0, "bw_active_drop");
        expect_at(c + 63, S_GPI, 32'h0440_0000, 32'h0, "bw_no_timeout");
        expect_at(c + 12, S_CACH, 32'h1, 32'h0, "cache_lat2");
        expect_at(c + 13, S_CACH, 32'h1, 32'h1, "cache_lat3");
        expect_at(c + 30, S_BSEL, 32'h1, 32'h0, "bsel_hold_mid");
        expect_at(c + 62, S_BSEL, 32'h1, 32'h0, "bsel_hold_last");
        expect_at(c + 63, S_BSEL, 32'h1, 32'h1, "bsel_update");
        wait_n(5);  rst_busy[2] = 1'b1;
        wait_n(5);  gpio_bus.GPIO_O[25] = 1'b1; gpio_bus.GPIO_O[24] = 1'b1;
        wait_n(49); rst_busy[2] = 1'b0;
        wait_n(7);  gpio_bus.GPIO_O[18] = 1'b0;

        // timeout on channel 1, then clear, then clear coincident with timeout
        wait_n(3); c = cyc; gpio_bus.GPIO_O[17] = 1'b1; rst_busy[1] = 1'b1;
        expect_at(c + 19, S_RST, 32'h2, 32'h0, "to_pulse_end");
        expect_at(c + 82, S_GPI, 32'h0002_0000, 32'h0002_0000, "to_waiting");
        expect_at(c + 83, S_GPI, 32'h0002_0000, 32'h0, "to_idle");
        expect_at(c + 83, S_GPI, 32'h0200_0000, 32'h0, "to_sticky_pre");
        expect_at(c + 84, S_GPI, 32'h0200_0000, 32'h0200_0000, "to_sticky_set");
        wait_n(86); gpio_bus.GPIO_O[17] = 1'b0;
        wait_n(2); d = cyc; gpio_bus.GPIO_O[20] = 1'b1;
        expect_at(d + 3, S_GPI, 32'h0200_0000, 32'h0200_0000, "clr_pre");
        expect_at(d + 4, S_GPI, 32'h0200_0000, 32'h0, "clr_done");
        wait_n(5); gpio_bus.GPIO_O[20] = 1'b0;
        wait_n(2); e = cyc; gpio_bus.GPIO_O[17] = 1'b1;
        expect_at(e + 83, S_GPI, 32'h0200_0000, 32'h0, "coinc_pre");
        expect_at(e + 84, S_GPI, 32'h0200_0000, 32'h0200_0000, "coinc_set_wins");
        expect_at(e + 90, S_GPI, 32'h0200_0000, 32'h0200_0000, "coinc_held");
        wait_n(80); gpio_bus.GPIO_O[20] = 1'b1;
        wait_n(12);
        gpio_bus.GPIO_O[20] = 1'b0; gpio_bus.GPIO_O[17] = 1'b0; rst_busy[1] = 1'b0;

        // cascade from channel 0
        wait_n(3); c = cyc; gpio_bus.GPIO_O[16] = 1'b1;
        expect_at(c + 2, S_RST, 32'h7, 32'h0, "cas_pre");
        for (int j = 0; j < 16; j++) expect_at(c + 3 + j, S_RST, 32'h7, 32'h7, "cas_high");
        expect_at(c + 19, S_RST, 32'h7, 32'h0, "cas_end");
        expect_at(c + 10, S_GPI, 32'h0007_0000, 32'h0001_0000, "cas_own_state");
        wait_n(25); gpio_bus.GPIO_O[16] = 1'b0;

        // cascade plus channel 1 retrigger at pulse cycle 10
        wait_n(3); c = cyc; gpio_bus.GPIO_O[16] = 1'b1;
        expect_at(c + 2, S_RST, 32'h2, 32'h0, "rt_pre");
        for (int j = 0; j < 26; j++) expect_at(c + 3 + j, S_RST, 32'h2, 32'h2, "rt_high");
        expect_at(c + 29, S_RST, 32'h2, 32'h0, "rt_end");
        expect_at(c + 18, S_RST, 32'h4, 32'h4, "rt_ch2_last");
        expect_at(c + 19, S_RST, 32'h4, 32'h0, "rt_ch2_end");
        wait_n(10); gpio_bus.GPIO_O[17] = 1'b1;
        wait_n(25); gpio_bus.GPIO_O[16] = 1'b0; gpio_bus.GPIO_O[17] = 1'b0;

        // async reset mid-ASSERT, release with request still high
        wait_n(3); c = cyc; gpio_bus.GPIO_O[16] = 1'b1;
        expect_at(c + 5, S_RST,  32'h7, 32'h7, "ar_asserting");
        expect_at(c + 6, S_RST,  32'h7, 32'h0, "ar_rst_out");
        expect_at(c + 6, S_GPI,  32'hFFFF_FFFF, 32'h0, "ar_gpio_i");
        expect_at(c + 6, S_CACH, 32'h1, 32'h0, "ar_cache_en");
        expect_at(c + 6, S_BSEL, 32'h1, 32'h0, "ar_bram_sel");
        wait_n(5);
        @(posedge ap_clk);
        #1 ap_rst_n = 1'b0;
        wait_n(3); ap_rst_n = 1'b1; r = cyc;
        expect_at(r + 2, S_RST, 32'h1, 32'h0, "rel_pre");
        for (int j = 0; j < 16; j++) expect_at(r + 3 + j, S_RST, 32'h1, 32'h1, "rel_pulse");
        for (int j = 19; j < 41; j++) expect_at(r + j, S_RST, 32'h1, 32'h0, "rel_single");
        expect_at(r + 2, S_CACH, 32'h1, 32'h0, "rel_cache_pre");
        expect_at(r + 3, S_CACH, 32'h1, 32'h1, "rel_cache");
        wait_n(43);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
